// File: rtl/pic_8259a_pkg.sv
// rtl/pic_8259a_pkg.sv - shared state encoding, OCW2 command codes and bit helpers for the 8259A sequencer
package pic_8259a_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK1 = 2'd1,
      ST_GAP  = 2'd2,
      ST_ACK2 = 2'd3
   } ack_state_t;

   // OCW2 {R,SL,EOI}
   localparam logic [2:0] OCW2_CLEAR_AUTO_ROT = 3'b000;
   localparam logic [2:0] OCW2_NONSPEC_EOI    = 3'b001;
   localparam logic [2:0] OCW2_NOP            = 3'b010;
   localparam logic [2:0] OCW2_SPEC_EOI       = 3'b011;
   localparam logic [2:0] OCW2_SET_AUTO_ROT   = 3'b100;
   localparam logic [2:0] OCW2_ROT_NONSPEC    = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIORITY   = 3'b110;
   localparam logic [2:0] OCW2_ROT_SPEC       = 3'b111;

   function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
      logic [15:0] doubled;
      doubled = {value, value} << amount;
      return doubled[15:8];
   endfunction

   function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
      logic [15:0] doubled;
      doubled = {value, value} >> amount;
      return doubled[7:0];
   endfunction

   function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
      logic [2:0] level;
      level = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) level = level | 3'(i);
      end
      return level;
   endfunction

endpackage

// File: rtl/pic_highest_in_service.sv
// rtl/pic_highest_in_service.sv - rotated priority scan of the ISR, returns the one-hot highest bit
module pic_highest_in_service
   import pic_8259a_pkg::*;
(
   input  logic [7:0] in_service_register,
   input  logic [2:0] priority_rotate,
   output logic [7:0] highest_level_in_service
);

   logic [2:0] scan_start;
   logic [7:0] rotated;
   logic [7:0] lowest_set;

   // Rotate so the highest-priority level lands on bit 0, isolate the lowest set bit, rotate back.
   assign scan_start               = priority_rotate + 3'd1;
   assign rotated                  = rotate_right(in_service_register, scan_start);
   assign lowest_set               = rotated & (~rotated + 8'd1);
   assign highest_level_in_service = rotate_left(lowest_set, scan_start);

endmodule

// File: rtl/pic_interrupt_ack_sequencer.sv
// rtl/pic_interrupt_ack_sequencer.sv - 8259A INT/INTA sequencer with ISR, OCW2 decode and rotation; PIC_AUTO_EOI_EN enables AEOI
module pic_interrupt_ack_sequencer
   import pic_8259a_pkg::*;
#(
   parameter int         IRQ_WIDTH      = 8,
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [IRQ_WIDTH-1:0] interrupt,
   input  logic                 interrupt_acknowledge,
   input  logic [4:0]           interrupt_vector_base,
   input  logic                 eoi_valid,
   input  logic [2:0]           eoi_command,
   input  logic [2:0]           eoi_level,
   input  logic                 auto_eoi_config,
   output logic                 interrupt_to_cpu,
   output logic [IRQ_WIDTH-1:0] in_service_register,
   output logic [IRQ_WIDTH-1:0] highest_level_in_service,
   output logic [2:0]           priority_rotate,
   output logic [IRQ_WIDTH-1:0] clear_interrupt_request,
   output logic [7:0]           data_out,
   output logic                 data_out_enable
);

   localparam logic [IRQ_WIDTH-1:0] IRQ_ONE = {{(IRQ_WIDTH-1){1'b0}}, 1'b1};

   ack_state_t           state, state_next;
   logic                 inta_q;
   logic                 inta_rise, inta_fall;
   logic [2:0]           level_q, level_next;
   logic                 spurious_q, spurious_next;
   logic                 int_next;
   logic [IRQ_WIDTH-1:0] isr_set, clear_next, aeoi_clear, eoi_clear, isr_next;
   logic                 aeoi_rotate;
   logic                 eoi_rot_valid;
   logic [2:0]           eoi_rot_level;
   logic [2:0]           rotate_next;
   logic                 auto_rotate;
   logic                 aeoi_active;

   assign inta_rise = interrupt_acknowledge & ~inta_q;
   assign inta_fall = ~interrupt_acknowledge & inta_q;

   pic_highest_in_service u_highest (
      .in_service_register      (in_service_register),
      .priority_rotate          (priority_rotate),
      .highest_level_in_service (highest_level_in_service)
   );

`ifdef PIC_AUTO_EOI_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         auto_rotate <= 1'b0;
      end else if (eoi_valid && eoi_command == OCW2_SET_AUTO_ROT) begin
         auto_rotate <= 1'b1;
      end else if (eoi_valid && eoi_command == OCW2_CLEAR_AUTO_ROT) begin
         auto_rotate <= 1'b0;
      end
   end
   assign aeoi_active = auto_eoi_config;
`else
   assign auto_rotate = 1'b0;
   assign aeoi_active = auto_eoi_config & 1'b0;
`endif

   always_comb begin
      state_next    = state;
      int_next      = 1'b0;
      level_next    = level_q;
      spurious_next = spurious_q;
      isr_set       = '0;
      clear_next    = '0;
      aeoi_clear    = '0;
      aeoi_rotate   = 1'b0;
      case (state)
         ST_IDLE: begin
            int_next = |interrupt;
            if (inta_rise) begin
               state_next = ST_ACK1;
               int_next   = 1'b0;
               if (interrupt == '0) begin
                  level_next    = SPURIOUS_LEVEL;
                  spurious_next = 1'b1;
               end else begin
                  level_next    = onehot_to_level(interrupt);
                  spurious_next = 1'b0;
                  isr_set       = IRQ_ONE << level_next;
                  clear_next    = IRQ_ONE << level_next;
               end
            end
         end
         ST_ACK1: if (inta_fall) state_next = ST_GAP;
         ST_GAP:  if (inta_rise) state_next = ST_ACK2;
         ST_ACK2: begin
            if (inta_fall) begin
               state_next = ST_IDLE;
               if (aeoi_active && !spurious_q) begin
                  aeoi_clear  = IRQ_ONE << level_q;
                  aeoi_rotate = auto_rotate;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      eoi_clear     = '0;
      eoi_rot_valid = 1'b0;
      eoi_rot_level = eoi_level;
      if (eoi_valid) begin
         case (eoi_command)
            OCW2_NONSPEC_EOI: eoi_clear = highest_level_in_service;
            OCW2_SPEC_EOI:    eoi_clear = IRQ_ONE << eoi_level;
            OCW2_ROT_NONSPEC: begin
               eoi_clear     = highest_level_in_service;
               eoi_rot_valid = |highest_level_in_service;
               eoi_rot_level = onehot_to_level(highest_level_in_service);
            end
            OCW2_ROT_SPEC: begin
               eoi_clear     = IRQ_ONE << eoi_level;
               eoi_rot_valid = 1'b1;
            end
            OCW2_SET_PRIORITY: eoi_rot_valid = 1'b1;
            OCW2_NOP, OCW2_SET_AUTO_ROT, OCW2_CLEAR_AUTO_ROT: ;
            default: ;
         endcase
      end
   end

   // An INTA set beats an EOI clear of the same bit; explicit EOI rotation beats AEOI rotation.
   assign isr_next    = (in_service_register & ~eoi_clear & ~aeoi_clear) | isr_set;
   assign rotate_next = eoi_rot_valid ? eoi_rot_level :
                        aeoi_rotate   ? level_q       : priority_rotate;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                   <= ST_IDLE;
         inta_q                  <= 1'b0;
         level_q                 <= 3'd0;
         spurious_q              <= 1'b0;
         interrupt_to_cpu        <= 1'b0;
         in_service_register     <= '0;
         clear_interrupt_request <= '0;
         priority_rotate         <= 3'd7;
      end else begin
         state                   <= state_next;
         inta_q                  <= interrupt_acknowledge;
         level_q                 <= level_next;
         spurious_q              <= spurious_next;
         interrupt_to_cpu        <= int_next;
         in_service_register     <= isr_next;
         clear_interrupt_request <= clear_next;
         priority_rotate         <= rotate_next;
      end
   end

   assign data_out_enable = (state == ST_ACK2);
   assign data_out        = data_out_enable ? {interrupt_vector_base, level_q} : 8'h00;

endmodule
